// File: rtl/multiword_add_seq.sv
// multiword_add_seq: drives a carry-less ripple adder one slice per cycle, LSB first.
// Build with MULTIWORD_ADD_SUB_EN defined to add the sub port (A-B mode).
module multiword_add_seq #(
    parameter int data_width = 4,
    parameter int num_words  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [data_width*num_words-1:0]  op_a,
    input  logic [data_width*num_words-1:0]  op_b,
    input  logic                             op_cin,
`ifdef MULTIWORD_ADD_SUB_EN
    input  logic                             sub,
`endif
    output logic [data_width-1:0]            add_a,
    output logic [data_width-1:0]            add_b,
    output logic                             add_cin,
    input  logic [data_width-1:0]            add_sum,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [data_width*num_words-1:0]  result,
    output logic                             carry_out
);
    localparam int TW = data_width * num_words;
    localparam int IW = (num_words > 1) ? $clog2(num_words) : 1;
    localparam logic [IW-1:0] LAST = IW'(num_words - 1);
    localparam int MSB = data_width - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [TW-1:0]         a_q, b_q;
    logic [IW-1:0]         idx;
    logic                  carry;
    logic                  sub_q, sub_in;
    logic                  accept, step, c_slice;
    logic [data_width-1:0] a_sl, b_sl;

`ifdef MULTIWORD_ADD_SUB_EN
    assign sub_in = sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= sub;
        end
    end
`else
    assign sub_in = 1'b0;
    assign sub_q  = 1'b0;
`endif

    assign accept = (state == IDLE) && in_valid;
    assign step   = (state == RUN);
    assign a_sl   = a_q[idx*data_width +: data_width];
    assign b_sl   = sub_q ? ~b_q[idx*data_width +: data_width]
                          :  b_q[idx*data_width +: data_width];

    // The adder hides its carry; recover it from the slice MSBs.
    assign c_slice = (a_sl[MSB] & b_sl[MSB])
                   | ((a_sl[MSB] | b_sl[MSB]) & ~add_sum[MSB]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (idx == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        unique case (state)
            IDLE: in_ready = 1'b1;
            RUN: begin
                add_a   = a_sl;
                add_b   = b_sl;
                add_cin = carry;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_q   <= op_a;
            b_q   <= op_b;
            idx   <= '0;
            carry <= op_cin | sub_in;
        end else if (step) begin
            result[idx*data_width +: data_width] <= add_sum;
            carry <= c_slice;
            idx   <= (idx == LAST) ? '0 : idx + 1'b1;
            if (idx == LAST) begin
                carry_out <= c_slice;
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: directed checks of the slice sequencer, 4x4 and 1x4 builds.
// Subtract cases are compiled only with MULTIWORD_ADD_SUB_EN defined.
module tb_multiword_add_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, op_cin, out_valid, out_ready, carry_out;
    logic [15:0] op_a, op_b, result;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin;

    logic        s_in_valid, s_in_ready, s_op_cin, s_out_valid, s_out_ready, s_carry_out;
    logic [3:0]  s_op_a, s_op_b, s_result;
    logic [3:0]  s_add_a, s_add_b, s_add_sum;
    logic        s_add_cin;

`ifdef MULTIWORD_ADD_SUB_EN
    logic        sub_drv;
`endif

    int tests = 0;
    int fails = 0;

    // Behavioural stand-in for the external ripple adder
    assign add_sum   = add_a + add_b + {3'b000, add_cin};
    assign s_add_sum = s_add_a + s_add_b + {3'b000, s_add_cin};

    multiword_add_seq #(.data_width(4), .num_words(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
`ifdef MULTIWORD_ADD_SUB_EN
        .sub(sub_drv),
`endif
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out)
    );

    multiword_add_seq #(.data_width(4), .num_words(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op_a(s_op_a), .op_b(s_op_b), .op_cin(s_op_cin),
`ifdef MULTIWORD_ADD_SUB_EN
        .sub(1'b0),
`endif
        .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin), .add_sum(s_add_sum),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .result(s_result), .carry_out(s_carry_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair and return 1ns after the acceptance edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
        end
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        op_cin = cin;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tests++;
        if ({out_valid, carry_out, result, add_a, add_b, add_cin} !== 27'd0) begin
            fails++;
            $display("FAIL reset_outputs: ov=%b co=%b res=%h a=%h b=%h cin=%b want all 0",
                     out_valid, carry_out, result, add_a, add_b, add_cin);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready, s_in_ready);
        end
    endtask

    task automatic test_carry_chain();
        logic [15:0] ea = 16'hFFFF;
        logic [15:0] eb = 16'h0001;
        logic [3:0]  ec = 4'b1110;
        send(16'hFFFF, 16'h0001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (add_a !== ea[k*4 +: 4] || add_b !== eb[k*4 +: 4] || add_cin !== ec[k]
                || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL chain_slice%0d: a=%h b=%h cin=%b ov=%b ir=%b want %h %h %b 0 0",
                         k, add_a, add_b, add_cin, out_valid, in_ready,
                         ea[k*4 +: 4], eb[k*4 +: 4], ec[k]);
            end
            tick();
        end
        tests++;
        if (out_valid !== 1'b1 || result !== 16'h0000 || carry_out !== 1'b1
            || add_a !== 4'h0 || add_b !== 4'h0) begin
            fails++;
            $display("FAIL chain_result: ov=%b res=%h co=%b a=%h b=%h want 1 0000 1 0 0",
                     out_valid, result, carry_out, add_a, add_b);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL chain_release: ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_cin();
        logic [3:0] ec = 4'b0001;
        send(16'h1234, 16'h4321, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (add_cin !== ec[k] || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL cin_slice%0d: cin=%b ir=%b want %b 0", k, add_cin, in_ready, ec[k]);
            end
            tick();
        end
        tests++;
        if (out_valid !== 1'b1 || result !== 16'h5556 || carry_out !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL cin_result: ov=%b res=%h co=%b ir=%b want 1 5556 0 0",
                     out_valid, result, carry_out, in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL cin_release: ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        send(16'h9ABC, 16'h7654, 1'b0);
        repeat (4) tick();
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (out_valid !== 1'b1 || result !== 16'h1110 || carry_out !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: ov=%b res=%h co=%b ir=%b want 1 1110 1 0",
                         k, out_valid, result, carry_out, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h1110 || carry_out !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: ov=%b ir=%b res=%h co=%b want 0 1 1110 1",
                     out_valid, in_ready, result, carry_out);
        end
    endtask

    task automatic test_reset_mid_run();
        logic seen = 1'b0;
        send(16'hAAAA, 16'h5555, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || result !== 16'h0000 || carry_out !== 1'b0 || add_a !== 4'h0) begin
            fails++;
            $display("FAIL midrst_clear: ov=%b res=%h co=%b a=%h want 0 0000 0 0",
                     out_valid, result, carry_out, add_a);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        tests++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_idle: ov_seen=%b ir=%b want 0 1", seen, in_ready);
        end
        send(16'h0001, 16'h0001, 1'b0);
        repeat (4) tick();
        tests++;
        if (out_valid !== 1'b1 || result !== 16'h0002 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL midrst_next: ov=%b res=%h co=%b want 1 0002 0", out_valid, result, carry_out);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_single_word();
        s_in_valid = 1'b1;
        s_op_a = 4'h9;
        s_op_b = 4'h8;
        s_op_cin = 1'b0;
        tick();
        s_in_valid = 1'b0;
        tests++;
        if (s_add_a !== 4'h9 || s_add_b !== 4'h8 || s_add_cin !== 1'b0 || s_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_run: a=%h b=%h cin=%b ov=%b want 9 8 0 0",
                     s_add_a, s_add_b, s_add_cin, s_out_valid);
        end
        tick();
        tests++;
        if (s_out_valid !== 1'b1 || s_result !== 4'h1 || s_carry_out !== 1'b1) begin
            fails++;
            $display("FAIL single_result: ov=%b res=%h co=%b want 1 1 1", s_out_valid, s_result, s_carry_out);
        end
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        tests++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_release: ov=%b ir=%b want 0 1", s_out_valid, s_in_ready);
        end
    endtask

`ifdef MULTIWORD_ADD_SUB_EN
    task automatic test_sub();
        sub_drv = 1'b1;
        send(16'h0005, 16'h0007, 1'b1);
        sub_drv = 1'b0;
        tests++;
        if (add_b !== 4'h8 || add_cin !== 1'b1) begin
            fails++;
            $display("FAIL sub_slice0: b=%h cin=%b want 8 1", add_b, add_cin);
        end
        repeat (4) tick();
        tests++;
        if (out_valid !== 1'b1 || result !== 16'hFFFE || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL sub_borrow: ov=%b res=%h co=%b want 1 fffe 0", out_valid, result, carry_out);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        sub_drv = 1'b1;
        send(16'h0007, 16'h0005, 1'b0);
        sub_drv = 1'b0;
        repeat (4) tick();
        tests++;
        if (out_valid !== 1'b1 || result !== 16'h0002 || carry_out !== 1'b1) begin
            fails++;
            $display("FAIL sub_noborrow: ov=%b res=%h co=%b want 1 0002 1", out_valid, result, carry_out);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        in_valid = 1'b0;
        out_ready = 1'b0;
        op_a = '0;
        op_b = '0;
        op_cin = 1'b0;
        s_in_valid = 1'b0;
        s_out_ready = 1'b0;
        s_op_a = '0;
        s_op_b = '0;
        s_op_cin = 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
        sub_drv = 1'b0;
`endif
        test_reset();
        test_carry_chain();
        test_cin();
        test_backpressure();
        test_reset_mid_run();
        test_single_word();
`ifdef MULTIWORD_ADD_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
